halut_encoder_ctrl: RTL and testbench

Sequencer for an array of EncUnits halut encoder units that share one start/enable. It programs each unit's threshold memory from a single config stream, then runs encoding row by row. Per row it holds encoder enable for exactly CPerEncUnit*TreeDepth cycles, then inserts one flush/idle cycle. It exports slot and level indices so the upstream input mux can feed each unit's a_input vector, and checks that all units report valid in lockstep.

---
 rtl/halut_pkg.sv | 33 +++
 rtl/halut_encoder_ctrl_if.sv | 23 ++
 rtl/halut_encoder_ctrl.sv | 164 ++++++++++++++++
 tb/tb_halut_encoder_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halut_pkg.sv
// Shared HALUT definitions: default array geometry, controller state encoding
// and width helpers used by the encoder, decoder and their sequencers.
package halut_pkg;

    localparam int HALUT_K         = 16;
    localparam int HALUT_C         = 32;
    localparam int HALUT_ENC_UNITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_ROW,
        ENCODE,
        FLUSH
    } halut_enc_ctrl_state_e;

    function automatic int tree_depth(input int k);
        return $clog2(k);
    endfunction

    function automatic int slot_width(input int c_per_unit);
        return $clog2(c_per_unit);
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int unit_width(input int units);
        return $clog2(units);
    endfunction

endpackage

// File: rtl/halut_encoder_ctrl_if.sv
// Threshold configuration stream into the encoder controller.
// The address carries {unit, local threshold address}.
interface halut_encoder_ctrl_if #(
    parameter int AddrWidth = 9,
    parameter int DataWidth = 16
);
    logic                 cfg_start;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [AddrWidth-1:0] cfg_addr;
    logic [DataWidth-1:0] cfg_data;
    logic                 cfg_last;

    modport master (
        output cfg_start, cfg_valid, cfg_addr, cfg_data, cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_addr, cfg_data, cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/halut_encoder_ctrl.sv
// Sequencer for a lockstep array of halut encoder units: loads thresholds,
// then runs each row for CPerEncUnit*TreeDepth enable cycles plus one flush.
//   state    | meaning
//   IDLE     | waiting for cfg_start or start
//   LOAD     | accepting threshold beats until cfg_last
//   WAIT_ROW | waiting for an upstream row of inputs
//   ENCODE   | encoder enable high, walking slot/level
//   FLUSH    | enable low for one cycle, row bookkeeping and valid check
module halut_encoder_ctrl
    import halut_pkg::*;
#(
    parameter int K             = HALUT_K,
    parameter int C             = HALUT_C,
    parameter int EncUnits      = HALUT_ENC_UNITS,
    parameter int DataTypeWidth = 16,
    parameter int MaxRows       = 1024,
    localparam int TreeDepth          = tree_depth(K),
    localparam int CPerEncUnit        = C / EncUnits,
    localparam int ThreshMemAddrWidth = $clog2(CPerEncUnit * K),
    localparam int UnitWidth          = unit_width(EncUnits),
    localparam int RowWidth           = $clog2(MaxRows + 1),
    localparam int SlotWidth          = slot_width(CPerEncUnit),
    localparam int LevelWidth         = level_width(TreeDepth)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    halut_encoder_ctrl_if.slave           cfg,
    output logic [EncUnits-1:0]           enc_we_o,
    output logic [ThreshMemAddrWidth-1:0] enc_waddr_o,
    output logic [DataTypeWidth-1:0]      enc_wdata_o,
    input  logic                          start_i,
    input  logic [RowWidth-1:0]           num_rows_i,
    input  logic                          row_valid_i,
    output logic                          row_ready_o,
    output logic                          encoder_o,
    output logic [SlotWidth-1:0]          c_slot_o,
    output logic [LevelWidth-1:0]         tree_level_o,
    input  logic [EncUnits-1:0]           enc_valid_i,
    output logic                          row_done_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int EncCycles   = CPerEncUnit * TreeDepth;
    localparam int TimerWidth  = $clog2(EncCycles);
    localparam int VCntWidth   = $clog2(EncCycles + 2);
    localparam int UnitMsb     = UnitWidth + ThreshMemAddrWidth - 1;

    halut_enc_ctrl_state_e state_q;
    logic [TimerWidth-1:0] timer_q;
    logic [VCntWidth-1:0]  vcnt_q;
    logic [RowWidth-1:0]   row_cnt_q;
    logic [RowWidth-1:0]   num_rows_q;
    logic                  cfg_ready_q;
    logic                  lockstep_bad;
    logic [VCntWidth-1:0]  vcnt_final;

    assign cfg.cfg_ready  = cfg_ready_q;
    assign lockstep_bad   = (|enc_valid_i) && !(&enc_valid_i);
    // The last codebook's valid lands in FLUSH, so it is folded in here
    assign vcnt_final     = vcnt_q + VCntWidth'(enc_valid_i[0]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            vcnt_q       <= '0;
            row_cnt_q    <= '0;
            num_rows_q   <= '0;
            cfg_ready_q  <= 1'b0;
            enc_we_o     <= '0;
            enc_waddr_o  <= '0;
            enc_wdata_o  <= '0;
            row_ready_o  <= 1'b0;
            encoder_o    <= 1'b0;
            c_slot_o     <= '0;
            tree_level_o <= '0;
            row_done_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            enc_we_o   <= '0;
            row_done_o <= 1'b0;
            done_o     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg.cfg_start) begin
                        state_q     <= LOAD;
                        cfg_ready_q <= 1'b1;
                        busy_o      <= 1'b1;
                    end else if (start_i) begin
                        err_o      <= 1'b0;
                        num_rows_q <= num_rows_i;
                        row_cnt_q  <= '0;
                        if (num_rows_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state_q     <= WAIT_ROW;
                            row_ready_o <= 1'b1;
                            busy_o      <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (cfg.cfg_valid) begin
                        enc_we_o[cfg.cfg_addr[UnitMsb -: UnitWidth]] <= 1'b1;
                        enc_waddr_o <= cfg.cfg_addr[ThreshMemAddrWidth-1:0];
                        enc_wdata_o <= cfg.cfg_data;
                        if (cfg.cfg_last) begin
                            state_q     <= IDLE;
                            cfg_ready_q <= 1'b0;
                            busy_o      <= 1'b0;
                        end
                    end
                end
                WAIT_ROW: begin
                    if (row_valid_i) begin
                        state_q      <= ENCODE;
                        row_ready_o  <= 1'b0;
                        encoder_o    <= 1'b1;
                        timer_q      <= TimerWidth'(EncCycles - 1);
                        vcnt_q       <= '0;
                        c_slot_o     <= '0;
                        tree_level_o <= '0;
                    end
                end
                ENCODE: begin
                    vcnt_q       <= vcnt_final;
                    tree_level_o <= tree_level_o + LevelWidth'(1);
                    if (tree_level_o == LevelWidth'(TreeDepth - 1))
                        c_slot_o <= c_slot_o + SlotWidth'(1);
                    if (timer_q == '0) begin
                        state_q      <= FLUSH;
                        encoder_o    <= 1'b0;
                        row_done_o   <= 1'b1;
                        c_slot_o     <= '0;
                        tree_level_o <= '0;
                    end else begin
                        timer_q <= timer_q - TimerWidth'(1);
                    end
                end
                FLUSH: begin
                    row_cnt_q <= row_cnt_q + RowWidth'(1);
                    if (vcnt_final != VCntWidth'(CPerEncUnit))
                        err_o <= 1'b1;
                    if (row_cnt_q + RowWidth'(1) == num_rows_q) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else begin
                        state_q     <= WAIT_ROW;
                        row_ready_o <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (lockstep_bad)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_halut_encoder_ctrl.sv
// Directed bench for halut_encoder_ctrl with a simple lockstep unit model
// producing one valid per codebook, the last one landing in the flush cycle.
module tb_halut_encoder_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [10:0] num_rows_i;
    logic        row_valid_i;
    logic        row_ready_o;
    logic        encoder_o;
    logic [2:0]  c_slot_o;
    logic [1:0]  tree_level_o;
    logic [3:0]  enc_valid_i;
    logic [3:0]  enc_we_o;
    logic [6:0]  enc_waddr_o;
    logic [15:0] enc_wdata_o;
    logic        row_done_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_chk = 0;
    int n_err = 0;

    int mon_enc   = 0;
    int mon_rd    = 0;
    int mon_done  = 0;
    int mon_valid = 0;
    int inj_req   = 0;

    int s_enc, s_rd, s_done, s_valid;

    halut_encoder_ctrl_if #(.AddrWidth(9), .DataWidth(16)) cfg_if ();

    halut_encoder_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg          (cfg_if),
        .enc_we_o     (enc_we_o),
        .enc_waddr_o  (enc_waddr_o),
        .enc_wdata_o  (enc_wdata_o),
        .start_i      (start_i),
        .num_rows_i   (num_rows_i),
        .row_valid_i  (row_valid_i),
        .row_ready_o  (row_ready_o),
        .encoder_o    (encoder_o),
        .c_slot_o     (c_slot_o),
        .tree_level_o (tree_level_o),
        .enc_valid_i  (enc_valid_i),
        .row_done_o   (row_done_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Unit model: valid after every 4th enable cycle; also tallies activity.
    initial begin : unit_model
        int  ev_cnt;
        bit  last_enc;
        bit  v;
        int  inj_done;
        ev_cnt   = 0;
        last_enc = 1'b0;
        inj_done = 0;
        enc_valid_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            v = last_enc && (ev_cnt != 0) && (ev_cnt % 4 == 0);
            if (inj_req != inj_done) begin
                enc_valid_i = 4'b0111;
                inj_done    = inj_req;
            end else begin
                enc_valid_i = {4{v}};
            end
            if (encoder_o) ev_cnt++;
            else ev_cnt = 0;
            last_enc = encoder_o;
            if (encoder_o)      mon_enc++;
            if (row_done_o)     mon_rd++;
            if (done_o)         mon_done++;
            if (enc_valid_i[0]) mon_valid++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic snap();
        s_enc   = mon_enc;
        s_rd    = mon_rd;
        s_done  = mon_done;
        s_valid = mon_valid;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while (!done_o && n < max_cyc) begin
            step();
            n++;
        end
        check_eq(tag, 32'(done_o), 1);
    endtask

    task automatic start_job(input int rows);
        num_rows_i = 11'(rows);
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
    endtask

    initial begin
        rst_ni            = 1'b0;
        start_i           = 1'b0;
        num_rows_i        = '0;
        row_valid_i       = 1'b0;
        cfg_if.cfg_start  = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_addr   = '0;
        cfg_if.cfg_data   = '0;
        cfg_if.cfg_last   = 1'b0;
        step();
        step();

        check_eq("rst_we",      32'(enc_we_o), 0);
        check_eq("rst_waddr",   32'(enc_waddr_o), 0);
        check_eq("rst_wdata",   32'(enc_wdata_o), 0);
        check_eq("rst_cfg_rdy", 32'(cfg_if.cfg_ready), 0);
        check_eq("rst_row_rdy", 32'(row_ready_o), 0);
        check_eq("rst_enc",     32'(encoder_o), 0);
        check_eq("rst_slot",    32'(c_slot_o), 0);
        check_eq("rst_level",   32'(tree_level_o), 0);
        check_eq("rst_flags",   32'({row_done_o, busy_o, done_o, err_o}), 0);
        rst_ni = 1'b1;
        step();

        // Config load: two beats, the second one last
        cfg_if.cfg_start = 1'b1;
        start_i          = 1'b1;
        num_rows_i       = 11'd1;
        step();
        cfg_if.cfg_start = 1'b0;
        start_i          = 1'b0;
        check_eq("load_rdy",  32'(cfg_if.cfg_ready), 1);
        check_eq("load_busy", 32'(busy_o), 1);
        check_eq("load_enc",  32'(encoder_o), 0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = {2'd1, 7'h02};
        cfg_if.cfg_data  = 16'h1234;
        cfg_if.cfg_last  = 1'b0;
        step();
        check_eq("beat1_we",    32'(enc_we_o), 32'h2);
        check_eq("beat1_waddr", 32'(enc_waddr_o), 32'h02);
        check_eq("beat1_wdata", 32'(enc_wdata_o), 32'h1234);
        check_eq("beat1_rdy",   32'(cfg_if.cfg_ready), 1);
        cfg_if.cfg_addr  = {2'd2, 7'h15};
        cfg_if.cfg_data  = 16'h3C00;
        cfg_if.cfg_last  = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_last  = 1'b0;
        check_eq("beat2_we",    32'(enc_we_o), 32'h4);
        check_eq("beat2_waddr", 32'(enc_waddr_o), 32'h15);
        check_eq("beat2_wdata", 32'(enc_wdata_o), 32'h3C00);
        check_eq("beat2_rdy",   32'(cfg_if.cfg_ready), 0);
        check_eq("beat2_busy",  32'(busy_o), 0);
        step();
        check_eq("post_we",     32'(enc_we_o), 0);
        check_eq("post_waddr",  32'(enc_waddr_o), 32'h15);

        // Single row with row_valid held
        snap();
        row_valid_i = 1'b1;
        start_job(1);
        check_eq("r1_busy",    32'(busy_o), 1);
        check_eq("r1_rowrdy",  32'(row_ready_o), 1);
        check_eq("r1_enc_pre", 32'(encoder_o), 0);
        for (int i = 0; i < 32; i++) begin
            step();
            check_eq($sformatf("r1_enc_%0d", i),   32'(encoder_o), 1);
            check_eq($sformatf("r1_slot_%0d", i),  32'(c_slot_o), 32'(i / 4));
            check_eq($sformatf("r1_level_%0d", i), 32'(tree_level_o), 32'(i % 4));
        end
        step();
        check_eq("r1_flush_enc", 32'(encoder_o), 0);
        check_eq("r1_row_done",  32'(row_done_o), 1);
        check_eq("r1_done_early", 32'(done_o), 0);
        step();
        check_eq("r1_done",      32'(done_o), 1);
        check_eq("r1_busy_end",  32'(busy_o), 0);
        check_eq("r1_rd_end",    32'(row_done_o), 0);
        check_eq("r1_enc_cnt",   32'(mon_enc - s_enc), 32);
        check_eq("r1_valid_cnt", 32'(mon_valid - s_valid), 8);
        check_eq("r1_err",       32'(err_o), 0);
        step();
        check_eq("r1_done_1cyc", 32'(done_o), 0);

        // Three rows with a 5-cycle stall before row 2
        snap();
        start_job(3);
        begin
            int n = 0;
            while (!row_done_o && n < 100) begin
                step();
                n++;
            end
        end
        check_eq("r3_first_rd", 32'(row_done_o), 1);
        row_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("r3_stall_enc_%0d", i), 32'(encoder_o), 0);
        end
        row_valid_i = 1'b1;
        wait_done(200, "r3_done_seen");
        check_eq("r3_rd_cnt",    32'(mon_rd - s_rd), 3);
        check_eq("r3_done_cnt",  32'(mon_done - s_done), 1);
        check_eq("r3_valid_cnt", 32'(mon_valid - s_valid), 24);
        check_eq("r3_enc_cnt",   32'(mon_enc - s_enc), 96);
        check_eq("r3_err",       32'(err_o), 0);
        step();

        // Zero-row job
        snap();
        start_job(0);
        check_eq("r0_done", 32'(done_o), 1);
        check_eq("r0_busy", 32'(busy_o), 0);
        step();
        check_eq("r0_done_1cyc", 32'(done_o), 0);
        check_eq("r0_enc_cnt",   32'(mon_enc - s_enc), 0);

        // Lockstep fault in ENCODE
        start_job(1);
        step();
        step();
        inj_req++;
        step();
        check_eq("lk_err_pre", 32'(err_o), 0);
        step();
        check_eq("lk_err_set", 32'(err_o), 1);
        wait_done(100, "lk_done_seen");
        check_eq("lk_err_at_done", 32'(err_o), 1);
        step();
        check_eq("lk_err_sticky", 32'(err_o), 1);
        start_job(1);
        check_eq("lk_err_clr", 32'(err_o), 0);
        wait_done(100, "lk_done2_seen");
        check_eq("lk_err_clean", 32'(err_o), 0);
        step();

        // Reset at ENCODE cycle 10, then a clean job
        start_job(2);
        for (int i = 0; i < 11; i++) step();
        check_eq("mr_slot_pre",  32'(c_slot_o), 2);
        check_eq("mr_level_pre", 32'(tree_level_o), 2);
        rst_ni = 1'b0;
        #1;
        check_eq("mr_enc",   32'(encoder_o), 0);
        check_eq("mr_busy",  32'(busy_o), 0);
        check_eq("mr_slot",  32'(c_slot_o), 0);
        check_eq("mr_level", 32'(tree_level_o), 0);
        check_eq("mr_rdy",   32'(row_ready_o), 0);
        step();
        rst_ni = 1'b1;
        step();
        snap();
        start_job(1);
        wait_done(100, "mr_done_seen");
        check_eq("mr_enc_cnt",   32'(mon_enc - s_enc), 32);
        check_eq("mr_valid_cnt", 32'(mon_valid - s_valid), 8);
        check_eq("mr_rd_cnt",    32'(mon_rd - s_rd), 1);
        check_eq("mr_err",       32'(err_o), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
